alu_issue_stage: RTL

- ID/EX pipeline register and operand-issue logic: the driver end of the EX-stage ALU interface (A, B, 3-bit ALUCtrl).
- Captures decoded instructions from ID and forwards results from the MEM and WB stages into the ALU operands.
- Detects load-use hazards, stalling ID and inserting a bubble.
- Sits between the decoder/register file and the ALU in the 5-stage MIPS pipeline.

---
 rtl/alu_issue_stage.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard detection.
// Define ISSUE_FWD_EN to build the MEM/WB forwarding muxes; without it, RAW hazards stall instead.
module alu_issue_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs_addr,
    input  logic [RW-1:0] id_rt_addr,
    input  logic          id_use_rs,
    input  logic          id_use_rt,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic          id_alusrc,
    input  logic [2:0]    id_aluctrl,
    input  logic [RW-1:0] id_rd_addr,
    input  logic          id_regwrite,
    input  logic          id_memtoreg,
    input  logic [RW-1:0] mem_rd_addr,
    input  logic          mem_regwrite,
    input  logic [DW-1:0] mem_result,
    input  logic [RW-1:0] wb_rd_addr,
    input  logic          wb_regwrite,
    input  logic [DW-1:0] wb_result,
    input  logic          flush,
    input  logic          ex_hold,
    output logic          stall_id,
    output logic          ex_valid,
    output logic [DW-1:0] ex_alu_a,
    output logic [DW-1:0] ex_alu_b,
    output logic [2:0]    ex_aluctrl,
    output logic [DW-1:0] ex_store_data,
    output logic [RW-1:0] ex_rd_addr,
    output logic          ex_regwrite,
    output logic          ex_memtoreg
);

    logic          valid_reg,    valid_next;
    logic [RW-1:0] rs_addr_reg,  rs_addr_next;
    logic [RW-1:0] rt_addr_reg,  rt_addr_next;
    logic [DW-1:0] rs_data_reg,  rs_data_next;
    logic [DW-1:0] rt_data_reg,  rt_data_next;
    logic [DW-1:0] imm_reg,      imm_next;
    logic          alusrc_reg,   alusrc_next;
    logic [2:0]    aluctrl_reg,  aluctrl_next;
    logic [RW-1:0] rd_addr_reg,  rd_addr_next;
    logic          regwrite_reg, regwrite_next;
    logic          memtoreg_reg, memtoreg_next;

    // Index 0 is the rs operand, index 1 is the rt operand.
    logic [RW-1:0] src_addr [2];
    logic [DW-1:0] src_data [2];
    logic [DW-1:0] fwd_data [2];
    logic [RW-1:0] id_addr  [2];
    logic          id_use   [2];
    logic          id_ex_match [2];
    logic          raw_match   [2];

    logic load_use;
    logic raw_hazard;
    logic hazard;

    assign src_addr[0] = rs_addr_reg;
    assign src_addr[1] = rt_addr_reg;
    assign src_data[0] = rs_data_reg;
    assign src_data[1] = rt_data_reg;
    assign id_addr[0]  = id_rs_addr;
    assign id_addr[1]  = id_rt_addr;
    assign id_use[0]   = id_use_rs;
    assign id_use[1]   = id_use_rt;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_opnd
            assign id_ex_match[gi] = id_use[gi] && (id_addr[gi] == rd_addr_reg);
`ifdef ISSUE_FWD_EN
            logic [DW-1:0] fwd_sel;
            // MEM is the younger producer, so it wins over WB.
            always_comb begin
                fwd_sel = src_data[gi];
                if (mem_regwrite && (mem_rd_addr != '0) && (mem_rd_addr == src_addr[gi]))
                    fwd_sel = mem_result;
                else if (wb_regwrite && (wb_rd_addr != '0) && (wb_rd_addr == src_addr[gi]))
                    fwd_sel = wb_result;
            end
            assign fwd_data[gi]  = fwd_sel;
            assign raw_match[gi] = 1'b0;
`else
            logic unused_addr;
            assign unused_addr   = ^src_addr[gi];
            assign fwd_data[gi]  = src_data[gi];
            // Without forwarding, any in-flight writer of a source register blocks issue.
            assign raw_match[gi] = id_use[gi] && (id_addr[gi] != '0) &&
                                   ((regwrite_reg && (rd_addr_reg == id_addr[gi])) ||
                                    (mem_regwrite && (mem_rd_addr == id_addr[gi])) ||
                                    (wb_regwrite  && (wb_rd_addr  == id_addr[gi])));
`endif
        end
    endgenerate

`ifndef ISSUE_FWD_EN
    logic unused_results;
    assign unused_results = ^{mem_result, wb_result};
`endif

    assign load_use   = id_valid && valid_reg && memtoreg_reg && (rd_addr_reg != '0) &&
                        (id_ex_match[0] || id_ex_match[1]);
    assign raw_hazard = id_valid && (raw_match[0] || raw_match[1]);
    assign hazard     = load_use || raw_hazard;
    assign stall_id   = hazard || ex_hold;

    always_comb begin
        valid_next    = valid_reg;
        rs_addr_next  = rs_addr_reg;
        rt_addr_next  = rt_addr_reg;
        rs_data_next  = rs_data_reg;
        rt_data_next  = rt_data_reg;
        imm_next      = imm_reg;
        alusrc_next   = alusrc_reg;
        aluctrl_next  = aluctrl_reg;
        rd_addr_next  = rd_addr_reg;
        regwrite_next = regwrite_reg;
        memtoreg_next = memtoreg_reg;
        if (!ex_hold) begin
            if (flush || hazard) begin
                valid_next    = 1'b0;
                rs_addr_next  = '0;
                rt_addr_next  = '0;
                rs_data_next  = '0;
                rt_data_next  = '0;
                imm_next      = '0;
                alusrc_next   = 1'b0;
                aluctrl_next  = '0;
                rd_addr_next  = '0;
                regwrite_next = 1'b0;
                memtoreg_next = 1'b0;
            end else begin
                valid_next    = id_valid;
                rs_addr_next  = id_rs_addr;
                rt_addr_next  = id_rt_addr;
                rs_data_next  = id_rs_data;
                rt_data_next  = id_rt_data;
                imm_next      = id_imm;
                alusrc_next   = id_alusrc;
                aluctrl_next  = id_aluctrl;
                rd_addr_next  = id_rd_addr;
                regwrite_next = id_regwrite;
                memtoreg_next = id_memtoreg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg    <= 1'b0;
            rs_addr_reg  <= '0;
            rt_addr_reg  <= '0;
            rs_data_reg  <= '0;
            rt_data_reg  <= '0;
            imm_reg      <= '0;
            alusrc_reg   <= 1'b0;
            aluctrl_reg  <= '0;
            rd_addr_reg  <= '0;
            regwrite_reg <= 1'b0;
            memtoreg_reg <= 1'b0;
        end else begin
            valid_reg    <= valid_next;
            rs_addr_reg  <= rs_addr_next;
            rt_addr_reg  <= rt_addr_next;
            rs_data_reg  <= rs_data_next;
            rt_data_reg  <= rt_data_next;
            imm_reg      <= imm_next;
            alusrc_reg   <= alusrc_next;
            aluctrl_reg  <= aluctrl_next;
            rd_addr_reg  <= rd_addr_next;
            regwrite_reg <= regwrite_next;
            memtoreg_reg <= memtoreg_next;
        end
    end

    assign ex_valid      = valid_reg;
    assign ex_alu_a      = fwd_data[0];
    assign ex_alu_b      = alusrc_reg ? imm_reg : fwd_data[1];
    assign ex_store_data = fwd_data[1];
    assign ex_aluctrl    = aluctrl_reg;
    assign ex_rd_addr    = rd_addr_reg;
    assign ex_regwrite   = regwrite_reg;
    assign ex_memtoreg   = memtoreg_reg;

endmodule
